// File: rtl/bsg_cache_to_dram_ctrl_dma_arb_pkg.sv
// Shared helpers for the cache DMA arbiter: width functions and the DMA
// direction encoding carried in the write_not_read bit of a DMA packet.
package bsg_cache_to_dram_ctrl_dma_arb_pkg;

    // Direction of a DMA packet, as encoded in its write_not_read bit
    typedef enum logic {
        e_dma_read  = 1'b0,
        e_dma_write = 1'b1
    } dma_dir_e;

    // clog2 that never returns 0, so single-entry selectors still get one bit
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Packet layout is {write_not_read, mask, addr}
    function automatic int dma_pkt_width(input int addr_w, input int mask_w);
        return 1 + mask_w + addr_w;
    endfunction

endpackage

// File: rtl/bsg_cache_to_dram_ctrl_dma_arb_id_fifo.sv
// Circular FIFO of cache indices with outstanding DMA bursts. Pushes are
// ignored while full and pops while empty; storage is not reset, only the
// pointers and occupancy count are.
module bsg_cache_to_dram_ctrl_dma_arb_id_fifo
    import bsg_cache_to_dram_ctrl_dma_arb_pkg::*;
#(
    parameter int els_p   = 4,
    parameter int width_p = 2,
    localparam int ptr_w_lp = safe_clog2(els_p),
    localparam int cnt_w_lp = safe_clog2(els_p + 1)
)(
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    input  logic               yumi_i,
    output logic               full_o,
    output logic               empty_o,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0]  mem_q [els_p];
    logic [width_p-1:0]  mem_d [els_p];
    logic [ptr_w_lp-1:0] wptr_q, wptr_d;
    logic [ptr_w_lp-1:0] rptr_q, rptr_d;
    logic [cnt_w_lp-1:0] cnt_q, cnt_d;
    logic                push;
    logic                pop;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == cnt_w_lp'(els_p));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rptr_q];
    assign push    = v_i & ~full_o;
    assign pop     = yumi_i & ~empty_o;

    // Next pointer, occupancy and storage contents
    always_comb begin
        wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = pop  ? ptr_inc(rptr_q) : rptr_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        mem_d = mem_q;
        if (push) begin
            mem_d[wptr_q] = data_i;
        end
    end

    // Pointer/count registers, cleared by the active-low synchronous reset
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Entry storage, data only, never reset
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/bsg_cache_to_dram_ctrl_dma_arb.sv
// Arbitrates several bsg_cache DMA channels onto a single packet/id channel
// towards bsg_cache_to_dram_ctrl, steers write data from the owning cache and
// returns read data to the requester in packet-accept order. No data is
// registered; only ownership (id FIFOs) and beat counts are state.
// Optional build macro: BSG_CACHE_DMA_ARB_FIXED_PRIO_EN selects fixed
// priority (lowest valid index wins) instead of round-robin.
module bsg_cache_to_dram_ctrl_dma_arb
    import bsg_cache_to_dram_ctrl_dma_arb_pkg::*;
#(
    parameter int num_dma_p        = 4,
    parameter int dma_addr_width_p = 32,
    parameter int dma_data_width_p = 64,
    parameter int dma_mask_width_p = 4,
    parameter int dma_burst_len_p  = 4,
    parameter int id_fifo_els_p    = 4,
    localparam int lg_num_dma_lp   = safe_clog2(num_dma_p),
    localparam int pkt_w_lp        = dma_pkt_width(dma_addr_width_p, dma_mask_width_p)
)(
    input  logic                                        clk_i,
    input  logic                                        reset_n_i,
    input  logic [num_dma_p-1:0][pkt_w_lp-1:0]          dma_pkt_i,
    input  logic [num_dma_p-1:0]                        dma_pkt_v_i,
    output logic [num_dma_p-1:0]                        dma_pkt_yumi_o,
    input  logic [num_dma_p-1:0][dma_data_width_p-1:0]  dma_data_i,
    input  logic [num_dma_p-1:0]                        dma_data_v_i,
    output logic [num_dma_p-1:0]                        dma_data_yumi_o,
    output logic [num_dma_p-1:0][dma_data_width_p-1:0]  dma_data_o,
    output logic [num_dma_p-1:0]                        dma_data_v_o,
    input  logic [num_dma_p-1:0]                        dma_data_ready_and_i,
    output logic [pkt_w_lp-1:0]                         ctrl_pkt_o,
    output logic                                        ctrl_pkt_v_o,
    input  logic                                        ctrl_pkt_yumi_i,
    output logic [lg_num_dma_lp-1:0]                    ctrl_pkt_id_o,
    output logic [dma_data_width_p-1:0]                 ctrl_wdata_o,
    output logic                                        ctrl_wdata_v_o,
    input  logic                                        ctrl_wdata_yumi_i,
    input  logic [dma_data_width_p-1:0]                 ctrl_rdata_i,
    input  logic                                        ctrl_rdata_v_i,
    output logic                                        ctrl_rdata_ready_and_o
);

    localparam int beat_w_lp = safe_clog2(dma_burst_len_p);

    typedef struct packed {
        logic                        write_not_read;
        logic [dma_mask_width_p-1:0] mask;
        logic [dma_addr_width_p-1:0] addr;
    } dma_pkt_s;

    logic [lg_num_dma_lp-1:0] rr_q, rr_d;
    logic [lg_num_dma_lp-1:0] winner;
    logic [lg_num_dma_lp-1:0] cand;
    logic                     found;
`ifndef BSG_CACHE_DMA_ARB_FIXED_PRIO_EN
    int                       idx;
`endif
    dma_pkt_s                 win_pkt;
    dma_dir_e                 win_dir;
    logic                     target_full;
    logic                     pkt_accept;

    logic                     wr_full, wr_empty, wr_push, wr_pop;
    logic                     rd_full, rd_empty, rd_push, rd_pop;
    logic [lg_num_dma_lp-1:0] wr_head, rd_head;

    logic [beat_w_lp-1:0]     wbeat_q, wbeat_d;
    logic [beat_w_lp-1:0]     rbeat_q, rbeat_d;
    logic                     wfire, rfire;
    logic                     wlast, rlast;

    function automatic logic [num_dma_p-1:0] onehot(input logic [lg_num_dma_lp-1:0] s);
        logic [num_dma_p-1:0] r;
        r    = '0;
        r[s] = 1'b1;
        return r;
    endfunction

    // Pick the first requesting channel, scanning from the rr pointer (or from 0)
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
`ifndef BSG_CACHE_DMA_ARB_FIXED_PRIO_EN
        idx    = 0;
`endif
        for (int i = 0; i < num_dma_p; i++) begin
`ifdef BSG_CACHE_DMA_ARB_FIXED_PRIO_EN
            cand = lg_num_dma_lp'(i);
`else
            idx = int'(rr_q) + i;
            if (idx >= num_dma_p) begin
                idx = idx - num_dma_p;
            end
            cand = lg_num_dma_lp'(idx);
`endif
            if (!found && dma_pkt_v_i[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign win_pkt        = dma_pkt_s'(dma_pkt_i[winner]);
    assign win_dir        = dma_dir_e'(win_pkt.write_not_read);
    // A blocked winner stalls the channel; no other requester is considered
    assign target_full    = (win_dir == e_dma_write) ? wr_full : rd_full;
    assign ctrl_pkt_o     = win_pkt;
    assign ctrl_pkt_id_o  = winner;
    assign ctrl_pkt_v_o   = (|dma_pkt_v_i) & ~target_full;
    assign pkt_accept     = ctrl_pkt_yumi_i & ctrl_pkt_v_o;
    assign dma_pkt_yumi_o = pkt_accept ? onehot(winner) : '0;
    assign wr_push        = pkt_accept & (win_dir == e_dma_write);
    assign rd_push        = pkt_accept & (win_dir == e_dma_read);

    // Write data comes from the cache at the head of the write-id FIFO
    assign ctrl_wdata_v_o  = ~wr_empty & dma_data_v_i[wr_head];
    assign ctrl_wdata_o    = dma_data_i[wr_head];
    assign wfire           = ctrl_wdata_yumi_i & ctrl_wdata_v_o;
    assign dma_data_yumi_o = wfire ? onehot(wr_head) : '0;
    assign wlast           = (wbeat_q == beat_w_lp'(dma_burst_len_p - 1));
    assign wr_pop          = wfire & wlast;

    // Read data is broadcast; only the head-of-FIFO cache sees valid
    assign dma_data_o             = {num_dma_p{ctrl_rdata_i}};
    assign dma_data_v_o           = (ctrl_rdata_v_i & ~rd_empty) ? onehot(rd_head) : '0;
    assign ctrl_rdata_ready_and_o = ~rd_empty & dma_data_ready_and_i[rd_head];
    assign rfire                  = ctrl_rdata_v_i & ctrl_rdata_ready_and_o;
    assign rlast                  = (rbeat_q == beat_w_lp'(dma_burst_len_p - 1));
    assign rd_pop                 = rfire & rlast;

    // Next rr pointer and beat counts
    always_comb begin
        rr_d = rr_q;
`ifdef BSG_CACHE_DMA_ARB_FIXED_PRIO_EN
        rr_d = '0;
`else
        if (pkt_accept) begin
            rr_d = (winner == lg_num_dma_lp'(num_dma_p - 1)) ? '0 : winner + 1'b1;
        end
`endif
        wbeat_d = wbeat_q;
        if (wfire) begin
            wbeat_d = wlast ? '0 : wbeat_q + 1'b1;
        end
        rbeat_d = rbeat_q;
        if (rfire) begin
            rbeat_d = rlast ? '0 : rbeat_q + 1'b1;
        end
    end

    // Control state registers with active-low synchronous reset
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rr_q    <= '0;
            wbeat_q <= '0;
            rbeat_q <= '0;
        end else begin
            rr_q    <= rr_d;
            wbeat_q <= wbeat_d;
            rbeat_q <= rbeat_d;
        end
    end

    bsg_cache_to_dram_ctrl_dma_arb_id_fifo #(
        .els_p   (id_fifo_els_p),
        .width_p (lg_num_dma_lp)
    ) wr_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (wr_push),
        .data_i    (winner),
        .yumi_i    (wr_pop),
        .full_o    (wr_full),
        .empty_o   (wr_empty),
        .data_o    (wr_head)
    );

    bsg_cache_to_dram_ctrl_dma_arb_id_fifo #(
        .els_p   (id_fifo_els_p),
        .width_p (lg_num_dma_lp)
    ) rd_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (rd_push),
        .data_i    (winner),
        .yumi_i    (rd_pop),
        .full_o    (rd_full),
        .empty_o   (rd_empty),
        .data_o    (rd_head)
    );

    // Read data with no outstanding read owner would be silently dropped
    rdata_has_owner_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(ctrl_rdata_v_i && rd_empty));

endmodule
